// File: rtl/bouncer_pkg.sv
// bouncer_pkg: playfield geometry defaults, FSM state encoding and centre helper.
// Rev 1.0
`default_nettype none

package bouncer_pkg;

  localparam int H_MAX_DEF      = 640;
  localparam int V_MAX_DEF      = 480;
  localparam int BALL_SIZE_DEF  = 8;
  localparam int PADDLE_X_DEF   = 20;
  localparam int PADDLE_LEN_DEF = 60;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE      = 2'd1,
    ST_MISS_HOLD = 2'd2
  } state_t;

  function automatic logic [9:0] centre(input int span, input int size);
    return 10'((span - size) / 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// tick_gen: free-running divider, tick high while the counter is all-ones.
// Rev 1.0
`default_nettype none

module tick_gen #(
  parameter int DIV_BITS = 17
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [DIV_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + DIV_BITS'(1);
  end

  assign tick = &cnt;

endmodule

`default_nettype wire

// File: rtl/ball_motion.sv
// ball_motion: Pong ball position/bounce engine with paddle hit test and miss hold-off.
// Rev 1.0
`default_nettype none

module ball_motion
  import bouncer_pkg::*;
#(
  parameter int DIV_BITS   = 17,
  parameter int H_MAX      = H_MAX_DEF,
  parameter int V_MAX      = V_MAX_DEF,
  parameter int BALL_SIZE  = BALL_SIZE_DEF,
  parameter int PADDLE_X   = PADDLE_X_DEF,
  parameter int PADDLE_LEN = PADDLE_LEN_DEF,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] linea1,
  input  logic       start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       miss,
  output logic [3:0] misses,
  output logic       busy
);

  localparam logic [9:0] X_LIM    = 10'(H_MAX - BALL_SIZE);
  localparam logic [9:0] Y_LIM    = 10'(V_MAX - BALL_SIZE);
  localparam logic [9:0] X_CTR    = centre(H_MAX, BALL_SIZE);
  localparam logic [9:0] Y_CTR    = centre(V_MAX, BALL_SIZE);
  localparam logic [9:0] STEP_V   = 10'(STEP);
  localparam logic [9:0] PAD_X    = 10'(PADDLE_X);
  localparam logic [9:0] PAD_EDGE = 10'(PADDLE_X + STEP);
  localparam int         HOLD_W   = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  state_t            state, state_nxt;
  logic              tick;
  logic [HOLD_W-1:0] hold_cnt;
  logic [9:0]        x_fwd, y_fwd;
  logic              at_paddle, hit, lose, hold_done;

  tick_gen #(.DIV_BITS(DIV_BITS)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign x_fwd     = ball_x + STEP_V;
  assign y_fwd     = ball_y + STEP_V;
  assign at_paddle = !dir_x && (ball_x <= PAD_EDGE);
  // Paddle span is widened to 11 bits so a paddle near the bottom cannot wrap.
  assign hit       = ({1'b0, ball_y} + 11'(BALL_SIZE) > {1'b0, linea1}) &&
                     ({1'b0, ball_y} < {1'b0, linea1} + 11'(PADDLE_LEN));
  assign lose      = at_paddle && !hit;
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start)             state_nxt = ST_MOVE;
      ST_MOVE:      if (tick && lose)      state_nxt = ST_MISS_HOLD;
      ST_MISS_HOLD: if (tick && hold_done) state_nxt = ST_MOVE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ball_x   <= X_CTR;
      ball_y   <= Y_CTR;
      dir_x    <= 1'b0;
      dir_y    <= 1'b1;
      miss     <= 1'b0;
      misses   <= 4'd0;
      hold_cnt <= '0;
    end else begin
      miss <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ball_x <= X_CTR;
            ball_y <= Y_CTR;
            dir_x  <= 1'b0;
            dir_y  <= 1'b1;
          end
        end
        ST_MOVE: begin
          if (tick) begin
            if (lose) begin
              // Position freezes; only the miss bookkeeping changes.
              miss     <= 1'b1;
              hold_cnt <= '0;
              if (misses != 4'hF) misses <= misses + 4'd1;
            end else begin
              if (dir_x) begin
                if (x_fwd >= X_LIM) begin
                  ball_x <= X_LIM;
                  dir_x  <= 1'b0;
                end else begin
                  ball_x <= x_fwd;
                end
              end else if (at_paddle) begin
                ball_x <= PAD_X;
                dir_x  <= 1'b1;
              end else begin
                ball_x <= ball_x - STEP_V;
              end

              if (dir_y) begin
                if (y_fwd >= Y_LIM) begin
                  ball_y <= Y_LIM;
                  dir_y  <= 1'b0;
                end else begin
                  ball_y <= y_fwd;
                end
              end else if (ball_y <= STEP_V) begin
                ball_y <= 10'd0;
                dir_y  <= 1'b1;
              end else begin
                ball_y <= ball_y - STEP_V;
              end
            end
          end
        end
        ST_MISS_HOLD: begin
          if (tick) begin
            if (hold_done) begin
              hold_cnt <= '0;
              ball_x   <= X_CTR;
              ball_y   <= Y_CTR;
              dir_x    <= 1'b0;
              dir_y    <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameter DIV_BITS, default 17, sets the movement tick period to 2^DIV_BITS clk cycles.
REQ-002 Parameter H_MAX, default 640, is the playfield width in pixels.
REQ-003 Parameter V_MAX, default 480, is the playfield height in pixels.
REQ-004 Parameter BALL_SIZE, default 8, is the ball edge length in pixels.
REQ-005 Parameter PADDLE_X, default 20, is the x coordinate of the paddle face (left bounce column).
REQ-006 Parameter PADDLE_LEN, default 60, is the paddle height in pixels.
REQ-007 Parameter STEP, default 1, is the pixels moved per tick on each axis.
REQ-008 Parameter HOLD_TICKS, default 64, is the number of ticks spent in MISS_HOLD.
REQ-009 There SHALL be one clock and a synchronous, active-low reset.
REQ-010 Port list (name, direction, width, meaning):
- clk, in, 1: sole clock, all logic on posedge.
- rst_n, in, 1: synchronous active-low reset.
- linea1, in, 10: paddle top y, unsigned.
- start, in, 1: level serve request.
- ball_x, out, 10: ball top-left x.
- ball_y, out, 10: ball top-left y.
- dir_x, out, 1: 1 = moving right.
- dir_y, out, 1: 1 = moving down.
- miss, out, 1: one-cycle pulse on a paddle miss.
- misses, out, 4: saturating miss count.
- busy, out, 1: high when state is not IDLE.

Function
REQ-011 The tick counter (DIV_BITS wide) SHALL increment every clk; tick SHALL be high for exactly the one cycle in which the counter is all-ones.
REQ-012 FSM states SHALL be IDLE, MOVE and MISS_HOLD.
REQ-013 IDLE: if start=1, the block SHALL load the centre position and directions (REQ-022) and enter MOVE on the next clk; start SHALL be ignored in all other states.
REQ-014 MOVE: positions and directions SHALL change only on tick cycles; new values SHALL be visible the cycle after tick (1-cycle latency).
REQ-015 Vertical motion SHALL follow these rules; all arithmetic is 10-bit unsigned and no intermediate value may wrap below 0.
- Moving down with ball_y+STEP >= V_MAX-BALL_SIZE: ball_y <= V_MAX-BALL_SIZE, dir_y <= 0.
- Moving up with ball_y <= STEP: ball_y <= 0, dir_y <= 1.
- Otherwise: ball_y <= ball_y ± STEP.
REQ-016 Right wall: when moving right with ball_x+STEP >= H_MAX-BALL_SIZE, the block SHALL set ball_x <= H_MAX-BALL_SIZE and dir_x <= 0.
REQ-017 Paddle column: when moving left with ball_x <= PADDLE_X+STEP, the block SHALL evaluate a hit using linea1 and the current ball_y sampled on the tick cycle.
- Hit condition: ball_y+BALL_SIZE > linea1 and ball_y < linea1+PADDLE_LEN.
- Hit: ball_x <= PADDLE_X, dir_x <= 1.
- Miss: miss pulses for 1 cycle, misses increments (saturating at 15), and the state becomes MISS_HOLD.
REQ-018 On a miss, ball_x/ball_y SHALL freeze at their pre-miss values, and no vertical update SHALL occur that tick.
REQ-019 Horizontal and vertical bounces on the same tick (corner) SHALL both be applied.
REQ-020 Otherwise, ball_x SHALL become ball_x ± STEP.
REQ-021 MISS_HOLD: the block SHALL count HOLD_TICKS ticks, then load centre values and re-enter MOVE without needing start.
REQ-022 Centre values: ball_x=(H_MAX-BALL_SIZE)/2 (316), ball_y=(V_MAX-BALL_SIZE)/2 (236), dir_x=0, dir_y=1.
REQ-023 linea1 changes between ticks SHALL have no effect; linea1+PADDLE_LEN SHALL be computed at 11 bits.

Reset
REQ-024 With rst_n=0 at a clk edge, the block SHALL set: state IDLE, tick counter 0, hold counter 0, ball_x=316, ball_y=236, dir_x=0, dir_y=1, miss=0, misses=0, busy=0.
REQ-025 Reset SHALL take priority over start, tick and any in-progress move or hold.

Structure
REQ-026 Package bouncer_pkg SHALL hold the geometry defaults and the state enumeration.
REQ-027 The tick divider SHALL be a separate sub-module, tick_gen (clk, rst_n -> tick).

Verification (bench uses DIV_BITS=2, defaults otherwise)
REQ-028 The bench SHALL cover these directed scenarios:
- Reset then idle with start=0 for 100 clk -> outputs hold 316/236, busy=0, tick pulses every 4 clk.
- start=1 for 1 clk -> busy=1 next clk; after first tick ball_x=315, ball_y=237.
- Ball forced to y=471 moving down, x mid-field -> next tick ball_y=472, dir_y=0; next tick ball_y=471.
- linea1=200, ball reaches x=21 with y=230 -> next tick ball_x=20, dir_x=1, miss stays 0.
- linea1=0, ball reaches x=21 with y=300 -> miss=1 for exactly 1 clk, misses=1; after 64 ticks ball at 316/236 in MOVE.
- rst_n=0 for 1 clk mid-MISS_HOLD with misses=15 -> all REQ-024 values, no re-serve until start.
